// File: rtl/pipe_fetch_regs.sv
// Fetch-side pipeline state for the decode controller: PC, the four
// instruction stage registers, the N/Z flags, the cycle counter and the
// RUN/HALT sequencer. The controller issues load/branch/flag strobes and reads
// these registers back. Every output comes straight from a flop.
//
// Strobe semantics: the inputs are level strobes that are sampled on each
// rising clock edge. There is no handshake. A strobe that is high at an edge
// acts at that edge. A strobe that is low leaves its register unchanged.
module pipe_fetch_regs #(
  parameter logic [7:0] PC_RESET  = 8'h00,
  parameter logic [7:0] NOP_INSTR = 8'h0A,
  parameter int         COUNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         mem_instr,
  input  logic [7:0]         alu_out,
  input  logic               alu_n,
  input  logic               alu_z,
  input  logic               PCwrite,
  input  logic               PCSel,
  input  logic               IRload,
  input  logic               IR3load,
  input  logic               IR4load,
  input  logic               FlagWrite,
  input  logic               IncCount,
  output logic [7:0]         pc,
  output logic [7:0]         IR,
  output logic [7:0]         IR2,
  output logic [7:0]         IR3,
  output logic [7:0]         IR4,
  output logic               N,
  output logic               Z,
  output logic [COUNT_W-1:0] count,
  output logic               halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state, state_next;

  logic branch3;
  logic taken;
  logic stop_ir;
  logic running;

  // A conditional branch (BZ/BNZ/BPZ) sitting in the execute stage resolves
  // as taken when the controller selects the ALU target.
  assign branch3 = (IR3[3:0] == 4'b0101) || (IR3[3:0] == 4'b1001) ||
                   (IR3[3:0] == 4'b1101);
  assign running = (state == RUN);
  assign taken   = running && branch3 && !PCSel;
  assign stop_ir = (IR[3:0] == 4'b0001);

  // The halted flag is the FSM state itself, so it rises the cycle after entry.
  assign halted = (state == HALT);

  // Next-state logic: STOP in decode halts the machine unless the PC is still
  // advancing or a taken branch is flushing the STOP off the wrong path.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (stop_ir && !PCwrite && !taken) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // State register; only reset leaves HALT.
  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // PC and the front three stage registers. A taken branch redirects the PC and
  // squashes IR..IR3. Otherwise each strobe acts on its own register. All of
  // them freeze once halted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc  <= PC_RESET;
      IR  <= NOP_INSTR;
      IR2 <= NOP_INSTR;
      IR3 <= NOP_INSTR;
    end else if (running) begin
      if (taken) begin
        pc  <= alu_out;
        IR  <= NOP_INSTR;
        IR2 <= NOP_INSTR;
        IR3 <= NOP_INSTR;
      end else begin
        if (PCwrite) pc <= pc + 8'd1;
        if (IRload) begin
          IR  <= mem_instr;
          IR2 <= IR;
        end
        if (IR3load) IR3 <= IR2;
      end
    end
  end

  // Writeback stage. The branch itself always retires on a flush. IR4 also
  // keeps draining on IR4load while halted.
  always_ff @(posedge clock) begin
    if (!reset)                 IR4 <= NOP_INSTR;
    else if (taken || IR4load)  IR4 <= IR3;
  end

  // Flags follow FlagWrite in every state, independent of flush or stall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      N <= 1'b0;
      Z <= 1'b0;
    end else if (FlagWrite) begin
      N <= alu_n;
      Z <= alu_z;
    end
  end

  // Cycle counter: counts in RUN only and sticks at all-ones.
  always_ff @(posedge clock) begin
    if (!reset)                                    count <= '0;
    else if (running && IncCount && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: tb/tb_pipe_fetch_regs.sv
// Self-checking bench for pipe_fetch_regs: a directed pass through reset,
// straight-line fetch, taken and not-taken branches, stall, STOP/halt and the
// PC/counter boundaries, followed by randomized traffic. A behavioural model
// built from stage arrays predicts every output.
module tb_pipe_fetch_regs;

  localparam logic [7:0] NOP = 8'h0A;
  localparam int SMALL_W = 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b0;
  logic [7:0] mem_instr = 8'h00, alu_out = 8'h00;
  logic       alu_n = 1'b0, alu_z = 1'b0;
  logic       PCwrite = 1'b0, PCSel = 1'b1, IRload = 1'b0, IR3load = 1'b0;
  logic       IR4load = 1'b0, FlagWrite = 1'b0, IncCount = 1'b0;

  logic [7:0]  pc, IR, IR2, IR3, IR4;
  logic        N, Z, halted;
  logic [15:0] count;

  logic [7:0]         s_pc, s_ir, s_ir2, s_ir3, s_ir4;
  logic               s_n, s_z, s_halted;
  logic [SMALL_W-1:0] s_count;

  pipe_fetch_regs dut (
    .clock(clock), .reset(reset), .mem_instr(mem_instr), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z), .PCwrite(PCwrite), .PCSel(PCSel),
    .IRload(IRload), .IR3load(IR3load), .IR4load(IR4load),
    .FlagWrite(FlagWrite), .IncCount(IncCount), .pc(pc), .IR(IR), .IR2(IR2),
    .IR3(IR3), .IR4(IR4), .N(N), .Z(Z), .count(count), .halted(halted)
  );

  // Narrow-counter instance so that saturation is reachable in a short run.
  pipe_fetch_regs #(.COUNT_W(SMALL_W)) dut_s (
    .clock(clock), .reset(reset), .mem_instr(mem_instr), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z), .PCwrite(PCwrite), .PCSel(PCSel),
    .IRload(IRload), .IR3load(IR3load), .IR4load(IR4load),
    .FlagWrite(FlagWrite), .IncCount(IncCount), .pc(s_pc), .IR(s_ir),
    .IR2(s_ir2), .IR3(s_ir3), .IR4(s_ir4), .N(s_n), .Z(s_z),
    .count(s_count), .halted(s_halted)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // st[0..3] = decode, register-read, execute, writeback.
  logic [7:0] st[4];
  logic [7:0] m_pc;
  logic       m_n, m_z, m_halted;
  int         m_cnt, m_cnt_s;

  function automatic bit is_branch(input logic [7:0] ins);
    return ins[3:0] inside {4'h5, 4'h9, 4'hD};
  endfunction

  always @(posedge clock) begin
    logic [7:0] nx[4];
    bit tk;
    if (!reset) begin
      for (int i = 0; i < 4; i++) st[i] = NOP;
      m_pc = 8'h00; m_n = 0; m_z = 0; m_halted = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      nx = st;
      tk = !m_halted && is_branch(st[2]) && !PCSel;
      if (FlagWrite) begin m_n = alu_n; m_z = alu_z; end
      if (m_halted) begin
        if (IR4load) nx[3] = st[2];
      end else begin
        if (tk) begin
          nx[0] = NOP; nx[1] = NOP; nx[2] = NOP; nx[3] = st[2];
          m_pc = alu_out;
        end else begin
          if (IR4load) nx[3] = st[2];
          if (IR3load) nx[2] = st[1];
          if (IRload) begin nx[1] = st[0]; nx[0] = mem_instr; end
          if (PCwrite) m_pc = 8'((m_pc + 1) % 256);
        end
        if (IncCount) begin
          if (m_cnt   < 65535)             m_cnt++;
          if (m_cnt_s < (1 << SMALL_W) - 1) m_cnt_s++;
        end
        if (st[0][3:0] == 4'h1 && !PCwrite && !tk) m_halted = 1;
      end
      st = nx;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("pc",      32'(pc),      32'(m_pc));
      check("IR",      32'(IR),      32'(st[0]));
      check("IR2",     32'(IR2),     32'(st[1]));
      check("IR3",     32'(IR3),     32'(st[2]));
      check("IR4",     32'(IR4),     32'(st[3]));
      check("N",       32'(N),       32'(m_n));
      check("Z",       32'(Z),       32'(m_z));
      check("count",   32'(count),   32'(m_cnt));
      check("halted",  32'(halted),  32'(m_halted));
      check("count_s", 32'(s_count), 32'(m_cnt_s));
      check("pc_s",    32'(s_pc),    32'(m_pc));
    end
  end

  // ---------------- drivers ----------------
  logic [7:0] mem[256];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Hold one set of controls for n cycles; memory answers at the current pc.
  task automatic drive(input int n, input bit pw, input bit ps, input bit il,
                       input bit i3, input bit i4, input logic [7:0] alu);
    for (int k = 0; k < n; k++) begin
      PCwrite = pw; PCSel = ps; IRload = il; IR3load = i3; IR4load = i4;
      alu_out = alu; IncCount = 1'b1;
      FlagWrite = 1'($urandom_range(0, 1));
      alu_n = 1'($urandom_range(0, 1)); alu_z = 1'($urandom_range(0, 1));
      mem_instr = mem[pc];
      tick();
    end
  endtask

  initial begin
    logic [7:0] pick[6];
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    mem[8'h00] = 8'h44; mem[8'h01] = 8'h86; mem[8'h04] = 8'h05;
    mem[8'h20] = 8'h05; mem[8'h21] = 8'h33; mem[8'h22] = 8'h77;
    mem[8'h24] = 8'h01;

    // Reset with every enable high.
    @(negedge clock);
    reset = 1'b0;
    PCwrite = 1; IRload = 1; IR3load = 1; IR4load = 1; IncCount = 1;
    FlagWrite = 1; alu_n = 1; alu_z = 1; mem_instr = 8'hFF; alu_out = 8'h55;
    tick(); tick();
    cmp_en = 1'b1;
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_ir", 32'({IR, IR2, IR3, IR4}), 32'h0A0A0A0A);
    check("rst_nz", 32'({N, Z, halted}), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    reset = 1'b1;

    // Straight-line fetch.
    drive(1, 1, 1, 1, 1, 1, 8'h00);
    check("sl_ir1", 32'(IR), 32'h44);
    drive(3, 1, 1, 1, 1, 1, 8'h00);
    check("sl_ir4", 32'(IR4), 32'h44);
    check("sl_ir3", 32'(IR3), 32'h86);
    check("sl_pc", 32'(pc), 32'h04);
    check("sl_count", 32'(count), 32'd4);

    // BZ moves into IR3, then resolves as taken toward 0x20.
    drive(3, 1, 1, 1, 1, 1, 8'h00);
    check("bz_ir3", 32'(IR3), 32'h05);
    drive(1, 1, 0, 1, 1, 1, 8'h20);
    check("bz_pc", 32'(pc), 32'h20);
    check("bz_flush", 32'({IR, IR2, IR3}), 32'h0A0A0A);
    check("bz_ir4", 32'(IR4), 32'h05);

    // A BZ at 0x20 that is not taken (PCSel=1) advances normally.
    drive(3, 1, 1, 1, 1, 1, 8'h00);
    drive(1, 1, 1, 1, 1, 1, 8'h99);
    check("nt_pc", 32'(pc), 32'h24);
    check("nt_ir", 32'({IR3, IR4}), 32'h3305);

    // Stall the front end for two cycles while the back end keeps moving.
    drive(2, 0, 1, 0, 1, 1, 8'h00);
    check("st_pc", 32'(pc), 32'h24);
    check("st_ir", 32'({IR, IR2, IR3, IR4}), 32'h0A777777);

    // STOP reaches IR, then PCwrite drops and the machine halts.
    drive(1, 1, 1, 1, 1, 0, 8'h00);
    drive(1, 0, 1, 0, 1, 0, 8'h00);
    check("stop_halt", 32'(halted), 32'h1);
    drive(10, 1, 0, 1, 1, 1, 8'h40);
    check("halt_pc", 32'(pc), 32'h25);
    check("halt_count", 32'(count), 32'd16);
    check("halt_ir4", 32'(IR4), 32'h0A);
    check("halt_hold", 32'(halted), 32'h1);

    // Reset brings the machine back to RUN.
    reset = 1'b0; tick(); reset = 1'b1;
    check("rr_halted", 32'(halted), 32'h0);
    check("rr_pc", 32'(pc), 32'h00);

    // STOP in IR together with a taken BPZ in IR3: no halt, jump to FF, wrap.
    mem[8'h00] = 8'h0D; mem[8'h01] = NOP; mem[8'h02] = 8'h01;
    drive(3, 1, 1, 1, 1, 1, 8'h00);
    check("sb_setup", 32'({IR, IR3}), 32'h010D);
    drive(1, 0, 0, 1, 1, 1, 8'hFF);
    check("sb_pc", 32'(pc), 32'hFF);
    check("sb_nohalt", 32'(halted), 32'h0);
    drive(1, 1, 1, 1, 1, 1, 8'h00);
    check("wrap_pc", 32'(pc), 32'h00);

    // Counter saturation on the narrow instance.
    reset = 1'b0; tick(); reset = 1'b1;
    drive(40, 1, 1, 0, 0, 0, 8'h00);
    check("sat_small", 32'(s_count), 32'h1F);
    check("sat_wide", 32'(count), 32'd40);

    // Randomized traffic with occasional resets to leave HALT.
    pick[0] = 8'h01; pick[1] = 8'h05; pick[2] = 8'h09;
    pick[3] = 8'h0D; pick[4] = NOP;   pick[5] = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) != 0);
      PCwrite   = 1'($urandom_range(0, 1));
      PCSel     = ($urandom_range(0, 3) != 0);
      IRload    = 1'($urandom_range(0, 1));
      IR3load   = 1'($urandom_range(0, 1));
      IR4load   = 1'($urandom_range(0, 1));
      FlagWrite = 1'($urandom_range(0, 1));
      IncCount  = 1'($urandom_range(0, 1));
      alu_n     = 1'($urandom_range(0, 1));
      alu_z     = 1'($urandom_range(0, 1));
      alu_out   = 8'($urandom_range(0, 255));
      mem_instr = pick[$urandom_range(0, 5)];
      if (mem_instr == 8'h00) mem_instr = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 1'b1;
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
